// File: rtl/sc_mult_if.sv
// sc_mult_if: request/result bundle for the shared stochastic multiplier
// scheduler. Two requester channels (valid/ready plus a 4-bit operand pair
// each), one result channel (valid/ready, id, ones count) and a busy flag.
// The slave modport is the scheduler side; the master modport is the side
// that sources operands and consumes results.
interface sc_mult_if #(
    parameter int LEN_LOG2 = 4
);
    logic                req0_valid;
    logic                req0_ready;
    logic [3:0]          req0_a;
    logic [3:0]          req0_b;
    logic                req1_valid;
    logic                req1_ready;
    logic [3:0]          req1_a;
    logic [3:0]          req1_b;
    logic                res_valid;
    logic                res_ready;
    logic                res_id;
    logic [LEN_LOG2:0]   res_count;
    logic                busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_id, res_count, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_id, res_count, busy
    );
endinterface

// File: rtl/sc_mult_scheduler.sv
// sc_mult_scheduler: round-robin scheduler for one shared bipolar stochastic
// multiplier. A granted operand pair drives a 2^LEN_LOG2-cycle run: two
// 31-bit LFSRs feed comparator SNGs, the bit streams are XNOR-multiplied and
// the ones are counted. The count is returned with the requester id.
//
// Build option: define SC_RESEED_EN to reload both LFSRs with their seeds on
// every accept (repeatable results). Without it, the LFSRs free-run across
// jobs and only reset restores the seeds.
//
// rst_n is asynchronous and active-high (asserted = 1), matching the
// surrounding design.
module sc_mult_scheduler #(
    parameter int          LEN_LOG2 = 4,
    parameter logic [30:0] SEED_A   = 31'd1,
    parameter logic [30:0] SEED_B   = 31'd2
) (
    input  logic    clk,
    input  logic    rst_n,
    sc_mult_if.slave bus
);

    localparam logic [LEN_LOG2:0] LEN_N   = {1'b1, {LEN_LOG2{1'b0}}};
    localparam logic [LEN_LOG2:0] CNT_ONE = {{LEN_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Next state of a 31-bit Fibonacci LFSR with taps 28 and 31.
    function automatic logic [30:0] lfsr_next(input logic [30:0] v);
        return {v[29:0], v[27] ^ v[30]};
    endfunction

    // One product bit: comparator SNGs on the low nibbles, XNOR multiply.
    function automatic logic sc_bit(input logic [30:0] la, input logic [30:0] lb,
                                    input logic [3:0] a, input logic [3:0] b);
        return ~((la[3:0] < a) ^ (lb[3:0] < b));
    endfunction

    state_t            state_r;
    logic              last_r;
    logic [3:0]        a_r;
    logic [3:0]        b_r;
    logic              id_r;
    logic [LEN_LOG2:0] count_r;
    logic [LEN_LOG2:0] cyc_r;
    logic [30:0]       lfsr_a_r;
    logic [30:0]       lfsr_b_r;
    logic              res_valid_r;
    logic              busy_r;

    logic              any_s;
    logic              grant_s;
    logic              accept_s;
    logic              bit_s;

    // Round-robin arbitration: on contention the requester other than last wins.
    always_comb begin
        any_s   = bus.req0_valid | bus.req1_valid;
        grant_s = ~last_r;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_s = ~last_r;
        end else if (bus.req0_valid) begin
            grant_s = 1'b0;
        end else if (bus.req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = ~last_r;
        end
    end

    // Ready is offered only in IDLE and only to the granted requester.
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        accept_s       = 1'b0;
        if (state_r == ST_IDLE && any_s) begin
            bus.req0_ready = ~grant_s;
            bus.req1_ready = grant_s;
            accept_s       = 1'b1;
        end else begin
            bus.req0_ready = 1'b0;
            bus.req1_ready = 1'b0;
            accept_s       = 1'b0;
        end
    end

    // Product bit for the current RUN cycle, from the present LFSR state.
    always_comb begin
        bit_s = sc_bit(lfsr_a_r, lfsr_b_r, a_r, b_r);
    end

    // Scheduler FSM: accept, run N stochastic cycles, hold result until taken.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            a_r         <= 4'd0;
            b_r         <= 4'd0;
            id_r        <= 1'b0;
            count_r     <= {(LEN_LOG2+1){1'b0}};
            cyc_r       <= {(LEN_LOG2+1){1'b0}};
            lfsr_a_r    <= SEED_A;
            lfsr_b_r    <= SEED_B;
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        a_r     <= grant_s ? bus.req1_a : bus.req0_a;
                        b_r     <= grant_s ? bus.req1_b : bus.req0_b;
                        id_r    <= grant_s;
                        last_r  <= grant_s;
                        count_r <= {(LEN_LOG2+1){1'b0}};
                        cyc_r   <= LEN_N;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
`ifdef SC_RESEED_EN
                        lfsr_a_r <= SEED_A;
                        lfsr_b_r <= SEED_B;
`endif
                    end
                end
                ST_RUN: begin
                    count_r  <= count_r + {{LEN_LOG2{1'b0}}, bit_s};
                    lfsr_a_r <= lfsr_next(lfsr_a_r);
                    lfsr_b_r <= lfsr_next(lfsr_b_r);
                    cyc_r    <= cyc_r - CNT_ONE;
                    if (cyc_r == CNT_ONE) begin
                        state_r     <= ST_DONE;
                        res_valid_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    res_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.res_valid = res_valid_r;
    assign bus.res_id    = id_r;
    assign bus.res_count = count_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_sc_mult_scheduler.sv
// Self-checking bench for sc_mult_scheduler. A job-level reference model
// tracks both LFSR values, the round-robin pointer and computes each
// expected ones count with plain integer arithmetic.
module tb_sc_mult_scheduler;

    localparam int          LEN_LOG2 = 4;
    localparam int          N        = 16;
    localparam logic [31:0] SEED_A   = 32'd1;
    localparam logic [31:0] SEED_B   = 32'd2;

    logic clk;
    logic rst_n;

    sc_mult_if #(.LEN_LOG2(LEN_LOG2)) bus ();

    sc_mult_scheduler #(
        .LEN_LOG2(LEN_LOG2),
        .SEED_A  (31'd1),
        .SEED_B  (31'd2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [31:0] la_m;
    logic [31:0] lb_m;
    int          last_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        la_m   = SEED_A;
        lb_m   = SEED_B;
        last_m = 1;
    endfunction

    // Ones count of one N-cycle job; advances the model LFSRs.
    function automatic int model_job(input int a, input int b);
        int cnt;
        int sa, sb;
        logic [31:0] fb;
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            sa = ((la_m % 16) < a) ? 1 : 0;
            sb = ((lb_m % 16) < b) ? 1 : 0;
            if (sa == sb) cnt = cnt + 1;
            fb   = ((la_m >> 27) ^ (la_m >> 30)) & 32'd1;
            la_m = ((la_m << 1) & 32'h7FFF_FFFF) | fb;
            fb   = ((lb_m >> 27) ^ (lb_m >> 30)) & 32'd1;
            lb_m = ((lb_m << 1) & 32'h7FFF_FFFF) | fb;
        end
        return cnt;
    endfunction

    // One full job: request, fixed-latency result, optional stall, handshake.
    task automatic job(input logic v0, input logic v1,
                       input logic [3:0] a0, input logic [3:0] b0,
                       input logic [3:0] a1, input logic [3:0] b1,
                       input int stall, output int cnt_out, output int id_out);
        int g, exp_cnt, oa, ob;
        logic [LEN_LOG2:0] held_cnt;
        logic              held_id;
        g  = (v0 && v1) ? (1 - last_m) : (v0 ? 0 : 1);
        oa = (g == 1) ? int'(a1) : int'(a0);
        ob = (g == 1) ? int'(b1) : int'(b0);
`ifdef SC_RESEED_EN
        la_m = SEED_A;
        lb_m = SEED_B;
`endif
        exp_cnt = model_job(oa, ob);
        last_m  = g;

        @(negedge clk);
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
        bus.res_ready  = (stall == 0);
        #1;
        check("grant_ready0", 32'(bus.req0_ready), 32'(g == 0));
        check("grant_ready1", 32'(bus.req1_ready), 32'(g == 1));
        check("idle_busy", 32'(bus.busy), 32'd0);

        @(posedge clk); #1;
        check("run_ready0", 32'(bus.req0_ready), 32'd0);
        check("run_ready1", 32'(bus.req1_ready), 32'd0);
        check("run_busy", 32'(bus.busy), 32'd1);

        repeat (N - 1) @(posedge clk);
        #1;
        check("early_valid", 32'(bus.res_valid), 32'd0);
        @(posedge clk); #1;
        check("latency_valid", 32'(bus.res_valid), 32'd1);
        check("res_count", 32'(bus.res_count), 32'(exp_cnt));
        check("res_id", 32'(bus.res_id), 32'(g));
        check("count_le_n", 32'(bus.res_count <= N), 32'd1);
        held_cnt = bus.res_count;
        held_id  = bus.res_id;

        if (stall > 0) begin
            repeat (stall) @(posedge clk);
            #1;
            check("stall_valid", 32'(bus.res_valid), 32'd1);
            check("stall_count", 32'(bus.res_count), 32'(exp_cnt));
            check("stall_id", 32'(bus.res_id), 32'(g));
            check("stall_ready0", 32'(bus.req0_ready), 32'd0);
            check("stall_ready1", 32'(bus.req1_ready), 32'd0);
            check("stall_busy", 32'(bus.busy), 32'd1);
            bus.res_ready = 1'b1;
        end

        @(posedge clk); #1;
        check("handshake_valid", 32'(bus.res_valid), 32'd0);
        check("handshake_busy", 32'(bus.busy), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cnt_out = int'(held_cnt);
        id_out  = int'(held_id);
    endtask

    initial begin
        int c, id, c1, c2, sel;
        logic [3:0] ra0, rb0, ra1, rb1;

        // Reset and reset values
        rst_n = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 4'd0; bus.req0_b = 4'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
        bus.res_ready  = 1'b1;
        model_reset();
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_res_count", 32'(bus.res_count), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready0_idle", 32'(bus.req0_ready), 32'd0);
        check("rst_ready1_idle", 32'(bus.req1_ready), 32'd0);
        bus.req0_valid = 1'b1;
        #1;
        check("rst_ready0_grant", 32'(bus.req0_ready), 32'd1);
        bus.req0_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;

        // a=0, b=0: every product bit is 1
        job(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 0, c, id);
        check("zero_ops_count", 32'(c), 32'd16);
        check("zero_ops_id", 32'(id), 32'd0);

        // Same operands twice from requester 1
        job(1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5, 0, c1, id);
        job(1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 4'd5, 0, c2, id);
`ifdef SC_RESEED_EN
        check("reseed_repeat", 32'(c2), 32'(c1));
`endif

        // Both requesters held valid: grants alternate starting at 0
        for (int i = 0; i < 4; i++) begin
            job(1'b1, 1'b1, 4'd7, 4'd3, 4'd12, 4'd10, 0, c, id);
            check("alternate_id", 32'(id), 32'(i % 2));
        end

        // Result stalled for 10 cycles
        job(1'b1, 1'b0, 4'd5, 4'd11, 4'd0, 4'd0, 10, c, id);

        // Reset pulsed at RUN cycle 5
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_a = 4'd3; bus.req0_b = 4'd7;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.req0_valid = 1'b0;
        #1;
        check("abort_res_valid", 32'(bus.res_valid), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_res_count", 32'(bus.res_count), 32'd0);
        check("abort_res_id", 32'(bus.res_id), 32'd0);
        check("abort_ready0", 32'(bus.req0_ready), 32'd0);
        check("abort_ready1", 32'(bus.req1_ready), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (N + 2) @(posedge clk);
        #1;
        check("abort_no_result", 32'(bus.res_valid), 32'd0);
        job(1'b1, 1'b0, 4'd3, 4'd7, 4'd0, 4'd0, 0, c, id);

        // Randomized jobs
        for (int j = 0; j < 200; j++) begin
            sel = int'($urandom_range(1, 3));
            ra0 = 4'($urandom); rb0 = 4'($urandom);
            ra1 = 4'($urandom); rb1 = 4'($urandom);
            job(1'(sel & 1), 1'((sel >> 1) & 1), ra0, rb0, ra1, rb1,
                int'($urandom_range(0, 2)), c, id);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
